// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC phase front end.
// Covers the pipeline latency, phase field layout, mode encoding and FSM state encoding.
package cordic_pkg;

  localparam int PIPE_LAT = 13;
  localparam int PHASE_W  = 18;

  // Phase word layout: quadrant on top of a 16-bit in-quadrant angle code
  localparam int QUAD_HI  = 17;
  localparam int QUAD_LO  = 16;
  localparam int ANGLE_HI = 15;
  localparam int ANGLE_LO = 0;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SWEEP = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cordic_phase_gen_valid_delay_line.sv
// Fixed-depth shift register that carries a valid strobe alongside the CORDIC pipeline.
// Only the asynchronous reset clears it, so samples already in flight still come out after a stop.
module valid_delay_line #(
  parameter int DEPTH = 13
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// NCO phase accumulator feeding the pipelined CORDIC.
// Supports fixed-frequency and chirp sweep modes, a programmable sample divider and a latency-matched valid strobe.
module cordic_phase_gen #(
  parameter int PIPE_LAT = cordic_pkg::PIPE_LAT,
  parameter int DIV_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Mode,
  input  logic [17:0]      Ftw,
  input  logic [17:0]      FtwStep,
  input  logic [17:0]      FtwMax,
  input  logic [17:0]      PhaseInit,
  input  logic [DIV_W-1:0] RateDiv,
  output logic [31:0]      Phase,
  output logic             PhaseValid,
  output logic             SinCosValid,
  output logic             SweepWrap,
  output logic             Busy
);

  import cordic_pkg::*;

  state_t             state;
  logic               mode_q;
  logic [PHASE_W-1:0] ftw_lat;
  logic [PHASE_W-1:0] step_lat;
  logic [PHASE_W-1:0] max_lat;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw_cur;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [PHASE_W:0]   ftw_nxt;

  assign tick    = (div_cnt == div_q);
  // One extra bit so a step past 2^18 still compares as above the limit
  assign ftw_nxt = {1'b0, ftw_cur} + {1'b0, step_lat};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_FIXED;
      ftw_lat    <= '0;
      step_lat   <= '0;
      max_lat    <= '0;
      acc        <= '0;
      ftw_cur    <= '0;
      div_q      <= '0;
      div_cnt    <= '0;
      Phase      <= '0;
      PhaseValid <= 1'b0;
      SweepWrap  <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      PhaseValid <= 1'b0;
      SweepWrap  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start && !Stop) begin
            mode_q   <= Mode;
            ftw_lat  <= Ftw;
            step_lat <= FtwStep;
            max_lat  <= FtwMax;
            div_q    <= RateDiv;
            acc      <= PhaseInit;
            ftw_cur  <= Ftw;
            div_cnt  <= '0;
            state    <= ST_RUN;
            Busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (Stop) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else if (tick) begin
            Phase      <= {{(32-PHASE_W){1'b0}}, acc};
            PhaseValid <= 1'b1;
            acc        <= acc + ftw_cur;
            div_cnt    <= '0;
            if (mode_q == MODE_SWEEP) begin
              if (ftw_nxt > {1'b0, max_lat}) begin
                ftw_cur   <= ftw_lat;
                SweepWrap <= 1'b1;
              end else begin
                ftw_cur <= ftw_nxt[PHASE_W-1:0];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  valid_delay_line #(
    .DEPTH(PIPE_LAT)
  ) u_valid_delay (
    .CLK  (CLK),
    .RST_N(RST_N),
    .din  (PhaseValid),
    .dout (SinCosValid)
  );

endmodule
